gf_serial_mul: RTL
==================

Name: gf_serial_mul

Overview:
- Parametrised bit-serial multiplier over GF(2^W) for the TRNG post-processing chain.
- Generalises the fixed GF(16) multiply-by-x to full A·B multiplication with a configurable field polynomial.
- Adds a valid/ready handshake and an optional accumulate mode (running XOR of products), so the post-processor can compute GF dot-products over raw RO bit words.

Parameters:
- W, 4: field/operand width in bits; legal range W >= 2.
- POLY, 4'b0011: low W bits of the reduction polynomial; the x^W term is implicit. The default is x^4+x+1. POLY[0] must be 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands A_IN, B_IN and ACC_IN are valid.
- IN_READY  output  1  block is idle and can accept operands.
- A_IN  input  W  multiplicand.
- B_IN  input  W  multiplier; consumed serially, MSB first.
- ACC_IN  input  1  1 = result is the product XOR the last delivered result; 0 = plain product.
- OUT_VALID  output  1  D_OUT holds a result.
- OUT_READY  input  1  consumer accepts D_OUT.
- D_OUT  output  W  result.
- BUSY  output  1  high while multiplication steps run.

Behaviour:
- Reset (RST high at a clock edge):
  - State goes to IDLE.
  - IN_READY=1, OUT_VALID=0, BUSY=0, D_OUT=0.
  - Internal accumulator (last delivered result) = 0; step counter = 0.
  - Reset mid-operation aborts the multiply with no output produced.
- xtime(v) is defined as {v[W-2:0],1'b0} XOR (v[W-1] ? POLY : 0). For W=4 and the default POLY this is {v[2:1], v[0]^v[3], v[3]}.
- State IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1: latch A_IN, B_IN and ACC_IN; clear the partial product P to 0; load the counter with W-1; go to BUSY; IN_READY drops to 0.
- State BUSY:
  - Each edge: P <= xtime(P) XOR (B[cnt] ? A : 0), starting from bit W-1; decrement cnt.
  - The edge that processes bit 0 is the final step. On that edge: D_OUT <= P_final XOR (acc_flag ? ACC : 0); OUT_VALID <= 1; BUSY <= 0; go to DONE.
  - Exactly W edges are spent in BUSY. OUT_VALID is first high W cycles after the accepting edge.
  - IN_VALID is ignored while BUSY.
- State DONE:
  - D_OUT is held stable while OUT_VALID=1 and OUT_READY=0. There is no limit on backpressure duration.
  - On an edge with OUT_READY=1: ACC <= D_OUT; OUT_VALID <= 0; IN_READY <= 1; go to IDLE.
  - No new operand is accepted in the same cycle as delivery. Minimum throughput is one result per W+2 cycles.
  - D_OUT keeps its last value after delivery; it is valid only while OUT_VALID=1.
- Operand boundary conditions:
  - A=0 or B=0 gives product 0.
  - Multiplying by 1 returns A unchanged.
  - Every reduction is applied per step, so D_OUT is always in reduced form.
- The accumulator updates only on delivery, never on accept or abort. The ACC_IN value applies to the operation it was latched with.
- Simultaneous RST and any handshake: reset wins.

Test Plan:
- Reset then multiply: RST for 2 cycles, then A=4'h2, B=4'h9, ACC_IN=0 → OUT_VALID rises 4 cycles after accept, D_OUT=4'h1, BUSY high for exactly 4 cycles.
- Plain product: A=4'h3, B=4'h7, ACC_IN=0 → D_OUT=4'h9. Then A=4'hF, B=4'hF → D_OUT=4'hA.
- Accumulate: deliver 2·9=4'h1, then A=3, B=7, ACC_IN=1 → D_OUT=4'h8. Then A=0, B=5, ACC_IN=1 → D_OUT=4'h8.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID → D_OUT stable, IN_READY=0, IN_VALID pulses ignored. Release → IN_READY=1 on the next cycle.
- Reset mid-operation: assert RST on the 2nd BUSY cycle → next cycle IN_READY=1, OUT_VALID=0, D_OUT=0. A following accumulate of 1·4'h6 yields 4'h6, proving ACC was cleared.
- Parameter sweep: W=8, POLY=8'h1B (AES field), A=8'h57, B=8'h83 → D_OUT=8'hC1 after 8 BUSY cycles. Randomised comparison against a reference model for 1000 operand pairs with random OUT_READY stalls.

Source files
------------

// File: rtl/gf_serial_mul.sv
// rtl/gf_serial_mul.sv - bit-serial GF(2^W) multiplier with handshake and XOR accumulate
//
// Purpose:
//   Multiplies A_IN by B_IN in GF(2^W). The field is defined by POLY, which
//   holds the low W bits of the reduction polynomial (the x^W term is
//   implicit). B is consumed one bit per clock, MSB first, so one product
//   takes W cycles. The result can optionally be XORed with the previous
//   delivered result, which lets a consumer build GF dot-products.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   A_IN/B_IN/ACC_IN valid
//   IN_READY   idle, operands are accepted on an IN_VALID edge
//   A_IN       multiplicand
//   B_IN       multiplier (serialised MSB first)
//   ACC_IN     1: result = product XOR last delivered result
//   OUT_VALID  D_OUT holds a result
//   OUT_READY  consumer takes D_OUT
//   D_OUT      result, always in reduced form
//   BUSY       multiplication steps in progress

module gf_serial_mul #(
    parameter int             W    = 4,
    parameter logic [W-1:0]   POLY = W'(4'b0011)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A_IN,
    input  logic [W-1:0] B_IN,
    input  logic         ACC_IN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] D_OUT,
    output logic         BUSY
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          acc_flag;
    logic [W-1:0]  p;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  step;

    // Multiply by x and reduce: shifting out the top bit means x^W was
    // produced, which is replaced by the low part of the polynomial.
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    // Horner step: P = P*x + B[cnt]*A, reduced every step.
    always_comb begin
        step = xtime(p) ^ (b_reg[cnt] ? a_reg : '0);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (IN_VALID)       state_next = S_BUSY;
            S_BUSY:  if (cnt == '0)      state_next = S_DONE;
            S_DONE:  if (OUT_READY)      state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        IN_READY  = (state == S_IDLE);
        BUSY      = (state == S_BUSY);
        OUT_VALID = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_flag <= 1'b0;
            p        <= '0;
            cnt      <= '0;
            acc      <= '0;
            D_OUT    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        a_reg    <= A_IN;
                        b_reg    <= B_IN;
                        acc_flag <= ACC_IN;
                        p        <= '0;
                        cnt      <= CW'(W - 1);
                    end
                end
                S_BUSY: begin
                    p   <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        D_OUT <= step ^ (acc_flag ? acc : '0);
                    end
                end
                S_DONE: begin
                    // The accumulator only ever holds delivered results.
                    if (OUT_READY) begin
                        acc <= D_OUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
